// File: rtl/syn_fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO slice.
// Pointers carry one extra wrap bit above the address bits.
package syn_fifo_pkg;

  localparam int def_addr_size  = 3;
  localparam int def_word_width = 8;
  localparam int def_af_th      = 6;
  localparam int def_ae_th      = 2;
  localparam bit def_fwft       = 1'b0;

  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int addr_size  = def_addr_size,
  parameter int word_width = def_word_width
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_size-1:0]  waddr,
  input  logic [word_width-1:0] wdata,
  input  logic [addr_size-1:0]  raddr,
  output logic [word_width-1:0] rdata
);

  logic [word_width-1:0] mem [2**addr_size];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_top.sv
// Synchronous FIFO with occupancy/threshold flags, sticky error flags, sync flush,
// and either registered-read or first-word-fall-through output.
module syn_fifo_top
  import syn_fifo_pkg::*;
#(
  parameter int addr_size  = def_addr_size,
  parameter int word_width = def_word_width,
  parameter int af_th      = def_af_th,
  parameter int ae_th      = def_ae_th,
  parameter bit fwft       = def_fwft
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_size:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int depth = 2**addr_size;
  localparam int pw    = ptr_width(addr_size);

  if (af_th > depth || ae_th >= af_th) begin : g_bad_cfg
    $error("syn_fifo_top: thresholds must satisfy ae_th < af_th <= depth");
  end

  localparam logic [pw-1:0] af_lvl = af_th[pw-1:0];
  localparam logic [pw-1:0] ae_lvl = ae_th[pw-1:0];

  logic [pw-1:0]         wr_ptr;
  logic [pw-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [word_width-1:0] mem_rdata;
  logic [word_width-1:0] dout_q;

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[pw-1] != rd_ptr[pw-1]) &&
                        (wr_ptr[pw-2:0] == rd_ptr[pw-2:0]);
  assign almost_full  = (count >= af_lvl);
  assign almost_empty = (count <= ae_lvl);

  // Flush outranks both requests, so neither memory nor pointers move on clr.
  assign wr_acc = wr & ~full & ~clr;
  assign rd_acc = rd & ~empty & ~clr;

  syn_fifo_mem #(
    .addr_size  (addr_size),
    .word_width (word_width)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[pw-2:0]),
    .wdata (data_in),
    .raddr (rd_ptr[pw-2:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end

  if (fwft) begin : g_fwft
    // dout_q remembers what was last shown so the output holds once empty.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dout_q <= '0;
      else       dout_q <= data_out;
    end
    assign data_out = empty ? dout_q : mem_rdata;
  end else begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       dout_q <= '0;
      else if (rd_acc) dout_q <= mem_rdata;
    end
    assign data_out = dout_q;
  end

endmodule
